// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants, state encoding and helpers for the register-file dump reader.
//   ADDR_W / DATA_W / NREGS : register index width, data width, register count
//   CNT_W                   : width of the requested/remaining count (0..NREGS)
//   state_e                 : FSM encoding (IDLE=0, FETCH=1, DRAIN=2, FINISH=3)
//   clamp_count()           : saturates a requested count at NREGS
package regfile_dump_reader_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // A request larger than the register file still visits each register once.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] req);
    logic [CNT_W-1:0] res;
    if (req > CNT_W'(NREGS)) begin
      res = CNT_W'(NREGS);
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_dump_reader_pair_buffer.sv
// Two-entry (index, data) buffer holding one fetched register pair.
// Entry 0 is always the head, so the head outputs come straight from flops.
//   clk, rst        : clock, asynchronous active-high reset
//   flush           : drop all entries (highest priority)
//   load, load_two  : load a pair; load_two=0 loads only entry 0
//   load_idx*/data* : pair to load
//   pop             : remove the head entry; entry 1 shifts into the head
//   head_idx/data   : current head entry
//   empty           : no valid entries
//   last_entry      : exactly one valid entry remains
module regdump_pair_buffer
  import regfile_dump_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              load_two,
  input  logic              pop,
  input  logic [ADDR_W-1:0] load_idx0,
  input  logic [DATA_W-1:0] load_data0,
  input  logic [ADDR_W-1:0] load_idx1,
  input  logic [DATA_W-1:0] load_data1,
  output logic [ADDR_W-1:0] head_idx,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              last_entry
);

  logic [ADDR_W-1:0] idx0_r;
  logic [DATA_W-1:0] data0_r;
  logic              v0_r;
  logic [ADDR_W-1:0] idx1_r;
  logic [DATA_W-1:0] data1_r;
  logic              v1_r;

  // Entry storage: flush beats load beats pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx0_r  <= '0;
      data0_r <= '0;
      v0_r    <= 1'b0;
      idx1_r  <= '0;
      data1_r <= '0;
      v1_r    <= 1'b0;
    end else if (flush) begin
      v0_r <= 1'b0;
      v1_r <= 1'b0;
    end else if (load) begin
      idx0_r  <= load_idx0;
      data0_r <= load_data0;
      v0_r    <= 1'b1;
      idx1_r  <= load_idx1;
      data1_r <= load_data1;
      v1_r    <= load_two;
    end else if (pop) begin
      idx0_r  <= idx1_r;
      data0_r <= data1_r;
      v0_r    <= v1_r;
      v1_r    <= 1'b0;
    end
  end

  // Entry 1 is only ever valid while entry 0 is, so v0_r alone decides emptiness.
  assign head_idx   = idx0_r;
  assign head_data  = data0_r;
  assign empty      = ~v0_r;
  assign last_entry = v0_r & ~v1_r;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a contiguous, wrapping range of the register file through both read
// ports and streams each value out as an (index, data) beat.
//   clk, rst            : clock, asynchronous active-high reset
//   start, first_idx,
//   count               : dump request (sampled in IDLE only; count clamps at NREGS)
//   abort               : cancel a dump in progress, no done pulse
//   busy, done          : dump in progress / one-cycle completion pulse
//   rd_addr0/1,
//   rd_data0/1          : register-file read ports (data is combinational)
//   out_valid/ready,
//   out_index/data/last : output beat stream
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  input  logic [DATA_W-1:0] rd_data0,
  input  logic [DATA_W-1:0] rd_data1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  state_e            state_r;
  state_e            state_next_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] ptr_next_s;
  logic [CNT_W-1:0]  rem_r;
  logic [CNT_W-1:0]  rem_next_s;
  logic [CNT_W-1:0]  cnt_clamped_s;

  logic              load_s;
  logic              load_two_s;
  logic              pop_s;
  logic              flush_s;
  logic              one_next_s;
  logic              buf_empty_s;
  logic              last_entry_s;
  logic [ADDR_W-1:0] head_idx_s;
  logic [DATA_W-1:0] head_data_s;

  logic              busy_r;
  logic              done_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic [ADDR_W-1:0] rd_addr0_r;
  logic [ADDR_W-1:0] rd_addr1_r;

  // Capture uses the registered read addresses, which equal ptr during FETCH.
  regdump_pair_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush_s),
    .load       (load_s),
    .load_two   (load_two_s),
    .pop        (pop_s),
    .load_idx0  (rd_addr0_r),
    .load_data0 (rd_data0),
    .load_idx1  (rd_addr1_r),
    .load_data1 (rd_data1),
    .head_idx   (head_idx_s),
    .head_data  (head_data_s),
    .empty      (buf_empty_s),
    .last_entry (last_entry_s)
  );

  // Next-state, pointer/count update and buffer control.
  always_comb begin
    state_next_s  = state_r;
    ptr_next_s    = ptr_r;
    rem_next_s    = rem_r;
    load_s        = 1'b0;
    load_two_s    = 1'b0;
    pop_s         = 1'b0;
    flush_s       = 1'b0;
    cnt_clamped_s = clamp_count(count);

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (cnt_clamped_s != CNT_W'(0)) begin
            ptr_next_s   = first_idx;
            rem_next_s   = cnt_clamped_s;
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_FINISH;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        load_s       = 1'b1;
        load_two_s   = (rem_r >= CNT_W'(2));
        ptr_next_s   = ptr_r + ADDR_W'(2);
        rem_next_s   = load_two_s ? (rem_r - CNT_W'(2)) : (rem_r - CNT_W'(1));
        state_next_s = ST_DRAIN;
      end
      ST_DRAIN: begin
        // out_valid is exactly "state is DRAIN", so ready alone completes a beat.
        if (out_ready) begin
          pop_s = 1'b1;
          if (last_entry_s) begin
            state_next_s = (rem_r == CNT_W'(0)) ? ST_FINISH : ST_FETCH;
          end else begin
            state_next_s = ST_DRAIN;
          end
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_FINISH: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    // Abort wins over everything; a beat handshaking this cycle still counts.
    if (abort && (state_r != ST_IDLE)) begin
      state_next_s = ST_IDLE;
      flush_s      = 1'b1;
      load_s       = 1'b0;
      pop_s        = 1'b0;
    end else begin
      flush_s = 1'b0;
    end
  end

  // Whether the buffer will hold exactly one entry next cycle (drives out_last).
  always_comb begin
    if (load_s) begin
      one_next_s = ~load_two_s;
    end else if (pop_s) begin
      one_next_s = ~last_entry_s & ~buf_empty_s;
    end else begin
      one_next_s = last_entry_s;
    end
  end

  // State, pointer, count and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      rem_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      rd_addr0_r  <= '0;
      rd_addr1_r  <= '0;
    end else begin
      state_r     <= state_next_s;
      ptr_r       <= ptr_next_s;
      rem_r       <= rem_next_s;
      busy_r      <= (state_next_s == ST_FETCH) || (state_next_s == ST_DRAIN);
      done_r      <= (state_next_s == ST_FINISH);
      out_valid_r <= (state_next_s == ST_DRAIN);
      out_last_r  <= (state_next_s == ST_DRAIN) && one_next_s && (rem_next_s == CNT_W'(0));
      // Addresses change only on entry to FETCH and hold otherwise.
      if (state_next_s == ST_FETCH) begin
        rd_addr0_r <= ptr_next_s;
        rd_addr1_r <= ptr_next_s + ADDR_W'(1);
      end
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_index = head_idx_s;
  assign out_data  = head_data_s;
  assign rd_addr0  = rd_addr0_r;
  assign rd_addr1  = rd_addr1_r;

endmodule
